event_indicator: RTL
====================

Name: event_indicator

Overview:
- Output-side counterpart of the button debouncer.
- The debouncer turns a long, noisy human press into a one-cycle pulse. This block turns one-cycle internal event pulses into human-visible, fixed-width LED blinks separated by a guaranteed dark gap.
- Events arriving while a blink is in progress are queued in a saturating counter and replayed in order.
- It sits between the computation/control logic (e.g. "result ready", "input accepted") and board LEDs.

Parameters:
- ON_CYCLES, 4, cycles the LED stays lit per event; must be >= 1.
- GAP_CYCLES, 2, dark cycles after each blink; must be >= 1.
- MAX_PENDING, 3, maximum queued events; must be >= 1.
- Derived widths: TW = $clog2(max(ON_CYCLES, GAP_CYCLES) + 1); PW = $clog2(MAX_PENDING + 1).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- pulse_in  in  1  event strobe; every cycle sampled high is one event.
- clr_ovf  in  1  clears the sticky overflow flag.
- led  out  1  registered indicator output.
- busy  out  1  high whenever the FSM is not IDLE.
- pending  out  PW  number of queued, not-yet-shown events.
- overflow  out  1  sticky; set when an event is dropped.

Behaviour:
- Reset (rst=1 at posedge):
  - Next cycle: led=0, busy=0, pending=0, overflow=0, state=IDLE, timer=0.
  - rst overrides all other inputs.
  - Mid-blink reset discards the current blink and all queued events.
- FSM states: IDLE, ON, GAP. Outputs: led = (state==ON); busy = (state!=IDLE). Both are derived from registered state, so there are no combinational paths from inputs.
- IDLE:
  - pulse_in=1 -> ON next cycle; timer loaded with ON_CYCLES-1; pending unchanged.
  - Latency from pulse to led high is exactly 1 cycle.
- ON:
  - Lasts exactly ON_CYCLES cycles.
  - On the timer==0 cycle: go to GAP, load timer with GAP_CYCLES-1.
- GAP:
  - Lasts exactly GAP_CYCLES cycles, with led=0.
  - On the timer==0 cycle (final gap cycle):
    - pending>0 -> ON; pending decrements by 1.
    - Otherwise, pulse_in=1 -> ON; pending stays 0 (event consumed directly).
    - Otherwise -> IDLE.
- Queueing:
  - pulse_in=1 while in ON, or in GAP before the final cycle: pending += 1 if pending < MAX_PENDING.
  - If pending == MAX_PENDING, the event is dropped and overflow is set.
- Simultaneous events:
  - Final GAP cycle with pending>0 and pulse_in=1: increment and decrement cancel; pending is unchanged; ON next.
  - If pending == MAX_PENDING in that same case, the event is accepted, not dropped (a slot frees that cycle).
- overflow:
  - Set has priority over clr_ovf in the same cycle.
  - Otherwise clr_ovf=1 clears it next cycle.
- pulse_in held high N cycles counts as N events. No edge detection here; upstream is responsible for producing one-cycle strobes.
- Timer is a down-counter of width TW. No arithmetic wrap is possible because it is always reloaded before reaching underflow.

Decomposition:
- Shared package contents:
  - state enum {IDLE, ON, GAP}.
  - Default-parameter constants.
  - Width helper function.
- One sub-module: cycle_timer.
  - Inputs: load, load_value, enable.
  - Output: done (count==0).
  - Used for both the ON and GAP phases.
- The queue counter and overflow flag stay in the top module.

Test Plan:
- Single pulse at cycle 0 -> led=1 cycles 1-4, led=0 cycles 5-6; busy=1 cycles 1-6, 0 at cycle 7; pending=0 throughout.
- Pulses at cycles 0,1,2 -> pending=1 at cycle 2 and 2 at cycle 3; blinks at cycles 1-4, 7-10 and 13-16; pending=1 at 7 and 0 at 13; busy drops at 19.
- Pulses at cycles 0-4 (MAX_PENDING=3):
  - Expected: pending=3 at cycle 4, overflow=1 at cycle 5, exactly 4 blinks.
  - clr_ovf at cycle 6 -> overflow=0 at cycle 7.
  - clr_ovf in the same cycle as a dropped pulse -> overflow stays 1.
- Pulses at cycles 0 and 6 (final GAP cycle) -> blinks 1-4 and 7-10; busy never drops between them; pending stays 0.
- Pulses at cycles 0,1; rst at cycle 3 -> cycle 4: led=0, busy=0, pending=0; pulse at cycle 5 -> led=1 at cycle 6.
- pulse_in held high for cycles 0-2 -> counted as 3 events -> 3 blinks, identical to the second scenario.

Source files
------------

// File: rtl/event_indicator_pkg.sv
// rtl/event_indicator_pkg.sv - shared states, default constants and width helper for event_indicator
package event_indicator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int DEF_ON_CYCLES   = 4;
  localparam int DEF_GAP_CYCLES  = 2;
  localparam int DEF_MAX_PENDING = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/event_indicator_cycle_timer.sv
// rtl/event_indicator_cycle_timer.sv - loadable down-counter that flags its final cycle
module cycle_timer #(
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_value,
  input  logic          enable,
  output logic          done
);

  logic [TW-1:0] count;

  // Reload wins over counting; the count parks at zero until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/event_indicator.sv
// rtl/event_indicator.sv - stretches one-cycle event strobes into LED blinks with a dark gap
module event_indicator
  import event_indicator_pkg::*;
#(
  parameter  int ON_CYCLES   = DEF_ON_CYCLES,
  parameter  int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter  int MAX_PENDING = DEF_MAX_PENDING,
  localparam int TW          = $clog2(max_int(ON_CYCLES, GAP_CYCLES) + 1),
  localparam int PW          = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pulse_in,
  input  logic          clr_ovf,
  output logic          led,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

  state_t        state;
  state_t        state_nx;
  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_done;

  logic final_gap;
  logic queue_evt;
  logic pend_full;
  logic pend_inc;
  logic pend_dec;
  logic drop_evt;

  cycle_timer #(
    .TW(TW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (tmr_load),
    .load_value(tmr_value),
    .enable    (state != IDLE),
    .done      (tmr_done)
  );

  // A pulse in the last gap cycle starts the next blink directly, so only
  // pulses seen during ON or the earlier gap cycles go through the queue.
  assign final_gap = (state == GAP) && tmr_done;
  assign queue_evt = pulse_in && ((state == ON) || ((state == GAP) && !tmr_done));
  assign pend_full = (pending == PEND_MAX);
  assign pend_inc  = queue_evt && !pend_full;
  assign drop_evt  = queue_evt && pend_full;
  // When a queued blink starts and a fresh pulse arrives together, the fresh
  // pulse takes the freed slot and the count stays put.
  assign pend_dec  = final_gap && (pending != '0) && !pulse_in;

  // Next-state and timer reload decisions.
  always_comb begin
    state_nx  = state;
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state)
      IDLE: begin
        if (pulse_in) begin
          state_nx  = ON;
          tmr_load  = 1'b1;
          tmr_value = ON_LOAD;
        end
      end
      ON: begin
        if (tmr_done) begin
          state_nx  = GAP;
          tmr_load  = 1'b1;
          tmr_value = GAP_LOAD;
        end
      end
      GAP: begin
        if (tmr_done) begin
          if ((pending != '0) || pulse_in) begin
            state_nx  = ON;
            tmr_load  = 1'b1;
            tmr_value = ON_LOAD;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // LED and busy are registered copies of the state they decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      led  <= 1'b0;
      busy <= 1'b0;
    end else begin
      led  <= (state_nx == ON);
      busy <= (state_nx != IDLE);
    end
  end

  // Saturating count of events still waiting for their blink.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else if (pend_inc) begin
      pending <= pending + 1'b1;
    end else if (pend_dec) begin
      pending <= pending - 1'b1;
    end
  end

  // Sticky drop flag; a new drop beats a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop_evt) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule
